// File: rtl/sipo_msb_pkg.sv
// Shared definitions for the MSB-first serial-to-parallel receiver.
// The serializer muxes use the same widths and state encoding.
//   DATA_WIDTH : width of the assembled parallel word
//   BEATS      : serial beats per frame
//   IDX_WIDTH  : width of the beat index (holds 0..BEATS)
//   QUAD_LANES : lane count in quad mode
//   state_t    : receiver states (IDLE, RECV)
package sipo_msb_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int BEATS      = 16;
    localparam int IDX_WIDTH  = 5;
    localparam int QUAD_LANES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/sipo_msb_demux.sv
// demux_msb: combinational beat-to-bit placement for the MSB-first receiver.
// Beat idx (1..BEATS) lands at the top of the word and walks downward.
// Ports:
//   idx     in  current beat index; 0 or out-of-range gives no write
//   mode    in  1 = quad (4 bits per beat), 0 = single (1 bit per beat)
//   sdata   in  serial lane data; only bit 0 is used in single mode
//   wr_en   out per-bit write enables into the shift word
//   wr_data out per-bit write data, valid where wr_en is set
module demux_msb #(
    parameter int DATA_WIDTH = sipo_msb_pkg::DATA_WIDTH,
    parameter int BEATS      = sipo_msb_pkg::BEATS,
    parameter int IDX_WIDTH  = sipo_msb_pkg::IDX_WIDTH
) (
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic                  mode,
    input  logic [3:0]            sdata,
    output logic [DATA_WIDTH-1:0] wr_en,
    output logic [DATA_WIDTH-1:0] wr_data
);
    import sipo_msb_pkg::*;

    localparam logic [DATA_WIDTH-1:0] QUAD_TOP   =
        {{QUAD_LANES{1'b1}}, {(DATA_WIDTH-QUAD_LANES){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] SINGLE_TOP = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX   = IDX_WIDTH'(BEATS);

    // Zero-based beat offset; quad mode scales it by four lanes.
    logic [7:0] shamt;

    always_comb begin
        shamt   = 8'(idx) - 8'd1;
        wr_en   = '0;
        wr_data = '0;
        if (idx != '0 && idx <= LAST_IDX) begin
            if (mode) begin
                wr_en   = QUAD_TOP >> {shamt, 2'b00};
                wr_data = {sdata, {(DATA_WIDTH-4){1'b0}}} >> {shamt, 2'b00};
            end else begin
                wr_en   = SINGLE_TOP >> shamt;
                wr_data = {sdata[0], {(DATA_WIDTH-1){1'b0}}} >> shamt;
            end
        end
    end

endmodule

// File: rtl/sipo_msb.sv
// sipo_msb: MSB-first serial-to-parallel receiver, quad or single lane.
// A frame is BEATS sampled beats; the completed word is published on pdata_o
// with a one-cycle valid_o pulse.
// Ports:
//   clk_i     in  clock, rising edge
//   reset_i   in  synchronous active-high reset
//   start_i   in  frame start, honoured only in IDLE
//   abort_i   in  drop the frame in progress (RECV only)
//   mode_i    in  lane mode, latched at start (1 = quad, 0 = single)
//   sample_i  in  beat strobe, honoured only in RECV
//   sdata_i   in  serial lane data
//   pdata_o   out last completed word
//   idx_o     out beat index: 0 idle, 1..BEATS in a frame
//   busy_o    out high while receiving
//   valid_o   out one-cycle pulse when pdata_o updates
//
// state | meaning
// IDLE  | waiting for start_i; sample_i and abort_i ignored
// RECV  | collecting beats; start_i ignored, abort_i drops the frame
module sipo_msb #(
    parameter int DATA_WIDTH = sipo_msb_pkg::DATA_WIDTH,
    parameter int BEATS      = sipo_msb_pkg::BEATS,
    parameter int IDX_WIDTH  = sipo_msb_pkg::IDX_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  mode_i,
    input  logic                  sample_i,
    input  logic [3:0]            sdata_i,
    output logic [DATA_WIDTH-1:0] pdata_o,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic                  busy_o,
    output logic                  valid_o
);
    import sipo_msb_pkg::*;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BEATS);

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] wr_en, wr_data;
    logic [DATA_WIDTH-1:0] word_merged;

    demux_msb #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEATS      (BEATS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_demux (
        .idx     (idx_q),
        .mode    (mode_q),
        .sdata   (sdata_i),
        .wr_en   (wr_en),
        .wr_data (wr_data)
    );

    // Word with the current beat folded in; used both for the shift word
    // and, on the last beat, directly for pdata so the final beat is included.
    assign word_merged = (word_q & ~wr_en) | (wr_data & wr_en);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            word_q  <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            word_q  <= word_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        word_d  = word_q;
        pdata_d = pdata_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RECV;
                    idx_d   = IDX_WIDTH'(1);
                    mode_d  = mode_i;
                    word_d  = '0;
                end
            end
            RECV: begin
                if (abort_i) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    word_d  = '0;
                end else if (sample_i) begin
                    word_d = word_merged;
                    if (idx_q == LAST_IDX) begin
                        pdata_d = word_merged;
                        valid_d = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign pdata_o = pdata_q;
    assign idx_o   = idx_q;
    assign busy_o  = (state_q == RECV);
    assign valid_o = valid_q;

endmodule
